lcd_msg_arbiter: RTL

LCD_MSG_ARBITER -- requirements
Module: lcd_msg_arbiter

---
 rtl/lcd_msg_arbiter_pkg.sv | 11 +
 rtl/lcd_msg_arbiter_rr_select.sv | 28 ++
 rtl/lcd_msg_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/lcd_msg_arbiter_pkg.sv
// lcd_msg_arbiter_pkg: the arbiter's state encoding and the default hold and watchdog limits.
package lcd_msg_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    HOLD  = 2'd3
  } arbState_t;
  localparam int HOLD_DEFAULT    = 12_500_000;
  localparam int TIMEOUT_DEFAULT = 1_048_576;
endpackage

// File: rtl/lcd_msg_arbiter_rr_select.sv
// rr_select: round-robin pick that searches upward from the index after last and wraps.
module rr_select
  import lcd_msg_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] cand;
  // Scan from farthest to nearest so the nearest requester after last is the final write.
  always_comb begin
    grant = '0;
    idx = '0;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (req[cand]) begin
        grant = '0;
        grant[cand] = 1'b1;
        idx = cand;
      end
    end
  end
endmodule

// File: rtl/lcd_msg_arbiter.sv
// lcd_msg_arbiter: grants one LCD message at a time, starts the print engine and holds the result on screen.
// Defining LCD_ARB_TIMEOUT_EN adds a print-engine watchdog driving a sticky oERR.
module lcd_msg_arbiter
  import lcd_msg_arbiter_pkg::*;
#(
  parameter int NREQ           = 3,
  parameter int MSG_W          = 2,
  parameter int HOLD_CYCLES    = HOLD_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic [NREQ-1:0]       iREQ,
  input  logic [NREQ*MSG_W-1:0] iMSG,
  output logic [NREQ-1:0]       oACK,
  output logic [MSG_W-1:0]      oMSG,
  output logic                  oSTART,
  input  logic                  iDONE,
  output logic                  oBUSY,
  output logic                  oERR
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
  arbState_t state, nextState;
  logic [IW-1:0] last, win;
  logic [NREQ-1:0] grant;
  logic [MSG_W-1:0] selMsg;
  logic [HW-1:0] holdCnt;
  logic holdEnd, wdEnd, grantNow;
  rr_select #(.NREQ(NREQ), .IW(IW)) uSel (
    .req  (iREQ),
    .last (last),
    .grant(grant),
    .idx  (win)
  );
  assign grantNow = state == IDLE && |iREQ;
  assign holdEnd  = holdCnt == HOLD_LAST;
  always_comb begin
    selMsg = '0;
    for (int i = 0; i < NREQ; i++) selMsg = grant[i] ? iMSG[i*MSG_W +: MSG_W] : selMsg;
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else state <= nextState;
  end
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    nextState = |iREQ ? START : IDLE;
      START:   nextState = BUSY;
      BUSY:    nextState = iDONE ? HOLD : wdEnd ? IDLE : BUSY;
      HOLD:    nextState = holdEnd ? IDLE : HOLD;
      default: nextState = IDLE;
    endcase
  end
  // The grant pulse is combinational, so it is gated by reset to stay low while iRST_N is asserted.
  always_comb begin
    oACK   = (state == IDLE && iRST_N) ? grant : '0;
    oSTART = state == START;
    oBUSY  = state != IDLE;
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      last    <= IW'(NREQ - 1);
      oMSG    <= '0;
      holdCnt <= '0;
    end else begin
      last    <= grantNow ? win : last;
      oMSG    <= grantNow ? selMsg : oMSG;
      holdCnt <= (state == BUSY && iDONE) ? '0 : (state == HOLD && !holdEnd) ? holdCnt + 1'b1 : holdCnt;
    end
  end
`ifdef LCD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  logic [TW-1:0] wdCnt;
  logic errQ;
  assign wdEnd = state == BUSY && wdCnt == WD_LAST;
  assign oERR  = errQ;
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wdCnt <= '0;
      errQ  <= 1'b0;
    end else begin
      wdCnt <= (state == BUSY && !wdEnd) ? wdCnt + 1'b1 : '0;
      errQ  <= errQ | (wdEnd && !iDONE);
    end
  end
`else
  assign wdEnd = 1'b0;
  assign oERR  = 1'b0;
`endif
endmodule
